// File: rtl/fifo_bank_pkg.sv
// fifo_bank_pkg: shared state encoding and counter-width helpers for the FIFO bank sequencer
package fifo_bank_pkg;
  localparam int NUM_FIFO_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int WCNT_W = $clog2(NUM_FIFO_DEF * DEPTH_DEF);
  localparam int DCNT_W = $clog2(DEPTH_DEF + NUM_FIFO_DEF);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
  function automatic int wcnt_w(input int n, input int d);
    return $clog2(n * d);
  endfunction
  function automatic int dcnt_w(input int n, input int d);
    return $clog2(d + n);
  endfunction
endpackage

// File: rtl/fifo_bank_ctrl_rden_skew_gen.sv
// rden_skew_gen: diagonal read-enable window per FIFO, empty suppression and registered read-valid
module rden_skew_gen #(
  parameter int NUM_FIFO = 8,
  parameter int DEPTH = 8,
  parameter int DW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active,
  input  logic [DW-1:0]       dcnt,
  input  logic [NUM_FIFO-1:0] fifo_empty,
  output logic [NUM_FIFO-1:0] fifo_rden,
  output logic                rd_miss,
  output logic [NUM_FIFO-1:0] rd_valid
);
  logic [NUM_FIFO-1:0] in_win, rd_valid_q;
  for (genvar i = 0; i < NUM_FIFO; i++) begin : g_win
    assign in_win[i] = active && int'(dcnt) >= i && int'(dcnt) < i + DEPTH;
  end
  assign fifo_rden = in_win & ~fifo_empty;
  assign rd_miss = |(in_win & fifo_empty);
  assign rd_valid = rd_valid_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_valid_q <= '0;
    else rd_valid_q <= fifo_rden;
endmodule

// File: rtl/fifo_bank_ctrl.sv
// fifo_bank_ctrl: fills a FIFO bank from a row-major byte stream, then drains it with systolic skew
module fifo_bank_ctrl
  import fifo_bank_pkg::*;
#(
  parameter int NUM_FIFO = 8,
  parameter int DEPTH = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic [NUM_FIFO-1:0] fifo_wren,
  output logic [DATA_W-1:0]   fifo_wdata,
  input  logic [NUM_FIFO-1:0] fifo_full,
  input  logic [NUM_FIFO-1:0] fifo_empty,
  output logic [NUM_FIFO-1:0] fifo_rden,
  output logic [NUM_FIFO-1:0] rd_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int WW = wcnt_w(NUM_FIFO, DEPTH);
  localparam int DW = dcnt_w(NUM_FIFO, DEPTH);
  localparam int TW = $clog2(NUM_FIFO);
  state_t state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic err_q, err_d, rd_miss, accept;
  logic [TW-1:0] tgt;
  assign tgt = TW'(32'(wcnt_q) / DEPTH);
  assign in_ready = state_q == FILL && !fifo_full[tgt];
  assign accept = in_valid && in_ready;
  assign fifo_wren = accept ? NUM_FIFO'(1) << tgt : '0;
  assign fifo_wdata = in_data;
  assign busy = state_q == FILL || state_q == DRAIN;
  assign done = state_q == DONE;
  assign err = err_q;
  rden_skew_gen #(.NUM_FIFO(NUM_FIFO), .DEPTH(DEPTH), .DW(DW)) u_skew (
    .clk(clk), .rst_n(rst_n), .active(state_q == DRAIN), .dcnt(dcnt_q),
    .fifo_empty(fifo_empty), .fifo_rden(fifo_rden), .rd_miss(rd_miss), .rd_valid(rd_valid)
  );
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    dcnt_d = dcnt_q;
    err_d = err_q | rd_miss;
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL;
        wcnt_d = '0;
        err_d = 1'b0;
      end
      FILL: if (accept) begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WW'(NUM_FIFO * DEPTH - 1)) begin
          state_d = DRAIN;
          dcnt_d = '0;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        state_d = dcnt_q == DW'(DEPTH + NUM_FIFO - 2) ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      dcnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      dcnt_q <= dcnt_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_fifo_bank_ctrl.sv
// tb_fifo_bank_ctrl: directed vectors against fifo_bank_ctrl driving a behavioural FIFO bank
module tb_fifo_bank_ctrl;
  localparam int NF = 8;
  localparam int D = 8;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [7:0] in_data = 0, fifo_wdata;
  logic in_ready, busy, done, err;
  logic [NF-1:0] fifo_wren, fifo_rden, rd_valid, fifo_full, fifo_empty;
  logic [NF-1:0] full_frc = '0, empty_frc = '0;
  logic [7:0] mem [NF][D];
  logic [2:0] wp [NF], rp [NF];
  logic [3:0] cnt [NF];
  logic [7:0] odata [NF];
  int checks = 0, errors = 0;
  typedef struct {
    logic [NF-1:0] rden;
    logic [NF-1:0] rdv;
    logic          busy;
    logic          done;
  } dvec_t;
  dvec_t tbl [16];

  always #5 clk = ~clk;

  fifo_bank_ctrl #(.NUM_FIFO(NF), .DEPTH(D), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
    .rd_valid(rd_valid), .busy(busy), .done(done), .err(err)
  );

  // FIFO bank model: capacity D per FIFO, o_data one cycle after rden
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NF; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        cnt[i] <= '0;
        odata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NF; i++) begin
        if (fifo_wren[i] && cnt[i] != 4'(D)) begin
          mem[i][wp[i]] <= fifo_wdata;
          wp[i] <= wp[i] + 3'd1;
        end
        if (fifo_rden[i] && cnt[i] != 4'd0) begin
          odata[i] <= mem[i][rp[i]];
          rp[i] <= rp[i] + 3'd1;
        end
        cnt[i] <= cnt[i] + 4'(fifo_wren[i] && cnt[i] != 4'(D)) - 4'(fifo_rden[i] && cnt[i] != 4'd0);
      end
    end

  always_comb
    for (int i = 0; i < NF; i++) begin
      fifo_full[i] = cnt[i] == 4'(D) || full_frc[i];
      fifo_empty[i] = cnt[i] == 4'd0 || empty_frc[i];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode 0 continuous, 1 in_valid toggling (first FILL cycle idle), 2 fifo 2 forced full 5 cycles + stray start
  task automatic run_fill(input logic [7:0] base, input int mode, input int exp_cyc);
    int cyc, wr;
    logic stall;
    cyc = 0;
    wr = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    while (busy && fifo_rden == '0 && cyc < 300) begin
      stall = mode == 2 && cyc >= 16 && cyc < 21;
      in_valid = mode == 1 ? cyc[0] : 1'b1;
      in_data = base + 8'(wr);
      full_frc = stall ? 8'h04 : 8'h00;
      start = mode == 2 && cyc == 18;
      #1;
      chk("fill_busy", 32'(busy), 1);
      chk("fill_wdata", 32'(fifo_wdata), 32'(in_data));
      if (stall) begin
        chk("stall_ready", 32'(in_ready), 0);
        chk("stall_wren", 32'(fifo_wren), 0);
      end else begin
        chk("fill_ready", 32'(in_ready), 1);
        chk("fill_wren", 32'(fifo_wren), in_valid ? 32'(1) << (wr / D) : 32'(0));
        if (in_valid) wr++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 0;
    full_frc = '0;
    start = 0;
    chk("fill_cycles", cyc, exp_cyc);
    chk("fill_writes", wr, NF * D);
  endtask

  task automatic drain_tbl(input logic [7:0] base, input logic [NF-1:0] emask);
    int k [NF] = '{default: 0};
    empty_frc = emask;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk("drain_rden", 32'(fifo_rden), 32'(tbl[c].rden & ~emask));
      chk("drain_rdv", 32'(rd_valid), 32'(tbl[c].rdv & ~emask));
      chk("drain_busy", 32'(busy), 32'(tbl[c].busy));
      chk("drain_done", 32'(done), 32'(tbl[c].done));
      for (int i = 0; i < NF; i++)
        if (rd_valid[i]) begin
          chk("drain_data", 32'(odata[i]), 32'(base + 8'(i * D + k[i])));
          k[i]++;
        end
      @(negedge clk);
    end
    empty_frc = '0;
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    for (int i = 0; i < NF; i++) chk("drain_count", k[i], emask[i] ? 0 : D);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{8'h01, 8'h00, 1'b1, 1'b0}, '{8'h03, 8'h01, 1'b1, 1'b0},
      '{8'h07, 8'h03, 1'b1, 1'b0}, '{8'h0F, 8'h07, 1'b1, 1'b0},
      '{8'h1F, 8'h0F, 1'b1, 1'b0}, '{8'h3F, 8'h1F, 1'b1, 1'b0},
      '{8'h7F, 8'h3F, 1'b1, 1'b0}, '{8'hFF, 8'h7F, 1'b1, 1'b0},
      '{8'hFE, 8'hFF, 1'b1, 1'b0}, '{8'hFC, 8'hFE, 1'b1, 1'b0},
      '{8'hF8, 8'hFC, 1'b1, 1'b0}, '{8'hF0, 8'hF8, 1'b1, 1'b0},
      '{8'hE0, 8'hF0, 1'b1, 1'b0}, '{8'hC0, 8'hE0, 1'b1, 1'b0},
      '{8'h80, 8'hC0, 1'b1, 1'b0}, '{8'h00, 8'h80, 1'b0, 1'b1}
    };
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wren", 32'(fifo_wren), 0);
    chk("rst_rden", 32'(fifo_rden), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    run_fill(8'h00, 0, 64);
    drain_tbl(8'h00, '0);
    @(negedge clk);
    run_fill(8'h40, 1, 128);
    drain_tbl(8'h40, '0);
    @(negedge clk);
    run_fill(8'h80, 2, 69);
    drain_tbl(8'h80, '0);
    chk("no_err", 32'(err), 0);
    @(negedge clk);
    run_fill(8'hC0, 0, 64);
    drain_tbl(8'hC0, 8'h20);
    chk("err_set", 32'(err), 1);
    repeat (2) @(negedge clk);
    #1;
    chk("err_sticky", 32'(err), 1);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    #1;
    chk("err_cleared", 32'(err), 0);
    chk("restart_busy", 32'(busy), 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_fill(8'h10, 0, 64);
    repeat (4) @(negedge clk);
    #1;
    chk("mid_rden", 32'(fifo_rden), 32'h1F);
    rst_n = 0;
    #1;
    chk("async_rden", 32'(fifo_rden), 0);
    chk("async_rd_valid", 32'(rd_valid), 0);
    chk("async_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_fill(8'h20, 0, 64);
    drain_tbl(8'h20, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
